// File: rtl/mpr_xfer_seq.sv
// CPU-side sequencer for the TAM/TMA MPR transfer instructions.
// Drives the MMU request port and pads each instruction to its architectural length.
module mpr_xfer_seq #(
  parameter int unsigned TAM_CYCLES = 5,
  parameter int unsigned TMA_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic       start,
  input  logic       op_tam,
  input  logic [7:0] imm,
  input  logic [7:0] acc_in,
  input  logic [7:0] mmu_d_out,
  output logic       load_en,
  output logic       store_en,
  output logic [7:0] MPR_mask,
  output logic [7:0] mmu_d_in,
  output logic [7:0] acc_out,
  output logic       acc_we,
  output logic       busy,
  output logic       done,
  output logic       mask_multi
);

  localparam int unsigned MAX_CYC = (TAM_CYCLES > TMA_CYCLES) ? TAM_CYCLES : TMA_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 4) ? $clog2(MAX_CYC - 3) : 1;
  localparam logic [CNT_W-1:0] TAM_PAD = CNT_W'(TAM_CYCLES - 4);
  localparam logic [CNT_W-1:0] TMA_PAD = CNT_W'(TMA_CYCLES - 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_PAD,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_q, op_nxt;
  logic [7:0]       imm_q, imm_nxt;

  logic       load_en_nxt, store_en_nxt, acc_we_nxt, busy_nxt, done_nxt, mask_multi_nxt;
  logic [7:0] mask_nxt, d_in_nxt, acc_out_nxt;
  logic [7:0] imm_low_bit;
  logic       imm_multi;

  // TMA reads exactly one MPR: the lowest selected one.
  assign imm_low_bit = imm & (~imm + 8'd1);
  assign imm_multi   = |(imm & (imm - 8'd1));

  // Next-state and next-output decode; outputs are registered one cycle later.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    op_nxt         = op_q;
    imm_nxt        = imm_q;
    load_en_nxt    = 1'b0;
    store_en_nxt   = 1'b0;
    mask_nxt       = 8'h00;
    d_in_nxt       = 8'h00;
    acc_out_nxt    = acc_out;
    acc_we_nxt     = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    mask_multi_nxt = mask_multi;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt      = S_ISSUE;
          op_nxt         = op_tam;
          imm_nxt        = imm;
          busy_nxt       = 1'b1;
          mask_multi_nxt = ~op_tam & imm_multi;
          if (op_tam) begin
            load_en_nxt = 1'b1;
            mask_nxt    = imm;
            d_in_nxt    = acc_in;
          end else begin
            store_en_nxt = 1'b1;
            mask_nxt     = imm_low_bit;
          end
        end
      end
      S_ISSUE: begin
        state_nxt = S_XFER;
        busy_nxt  = 1'b1;
      end
      S_XFER: begin
        state_nxt = S_PAD;
        busy_nxt  = 1'b1;
        cnt_nxt   = op_q ? TAM_PAD : TMA_PAD;
        // MMU presents the selected MPR during this cycle; a zero mask reads nothing.
        if (!op_q && (imm_q != 8'h00)) begin
          acc_out_nxt = mmu_d_out;
          acc_we_nxt  = 1'b1;
        end
      end
      S_PAD: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt  = cnt - CNT_W'(1);
          busy_nxt = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= 1'b0;
      imm_q      <= 8'h00;
      load_en    <= 1'b0;
      store_en   <= 1'b0;
      MPR_mask   <= 8'h00;
      mmu_d_in   <= 8'h00;
      acc_out    <= 8'h00;
      acc_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mask_multi <= 1'b0;
    end else if (RDY) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      op_q       <= op_nxt;
      imm_q      <= imm_nxt;
      load_en    <= load_en_nxt;
      store_en   <= store_en_nxt;
      MPR_mask   <= mask_nxt;
      mmu_d_in   <= d_in_nxt;
      acc_out    <= acc_out_nxt;
      acc_we     <= acc_we_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      mask_multi <= mask_multi_nxt;
    end
  end

endmodule

// File: tb/tb_mpr_xfer_seq.sv
// Self-checking bench for mpr_xfer_seq: directed table, stall/reset sequences and
// randomized instructions against an MPR/accumulator reference model.
module tb_mpr_xfer_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RDY = 1'b1;
  logic       start = 1'b0;
  logic       op_tam = 1'b0;
  logic [7:0] imm = 8'h00;
  logic [7:0] acc_in = 8'h00;
  logic [7:0] mmu_d_out;
  logic       load_en, store_en, acc_we, busy, done, mask_multi;
  logic [7:0] MPR_mask, mmu_d_in, acc_out;

  always #5 clk = ~clk;

  mpr_xfer_seq dut (
    .clk       (clk),
    .reset     (reset),
    .RDY       (RDY),
    .start     (start),
    .op_tam    (op_tam),
    .imm       (imm),
    .acc_in    (acc_in),
    .mmu_d_out (mmu_d_out),
    .load_en   (load_en),
    .store_en  (store_en),
    .MPR_mask  (MPR_mask),
    .mmu_d_in  (mmu_d_in),
    .acc_out   (acc_out),
    .acc_we    (acc_we),
    .busy      (busy),
    .done      (done),
    .mask_multi(mask_multi)
  );

  // Behavioural MMU: LOAD writes masked MPRs, STORE presents the selected MPR next cycle.
  logic       mmu_clr = 1'b1;
  logic [7:0] mmu_mpr [8];
  logic [7:0] store_sel;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      store_sel <= 8'h00;
      if (mmu_clr) for (int i = 0; i < 8; i++) mmu_mpr[i] <= 8'h00;
    end else if (RDY) begin
      if (load_en) for (int i = 0; i < 8; i++) if (MPR_mask[i]) mmu_mpr[i] <= mmu_d_in;
      store_sel <= store_en ? MPR_mask : 8'h00;
    end
  end

  always_comb begin
    mmu_d_out = 8'hA5;
    for (int i = 7; i >= 0; i--) if (store_sel[i]) mmu_d_out = mmu_mpr[i];
  end

  // Reference architectural state
  logic [7:0] ref_mpr [8];
  logic [7:0] ref_acc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       op;
    logic [7:0] imm;
    logic [7:0] acc;
    logic [7:0] exp_mask;
    logic       exp_multi;
    int         exp_n;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [29:0] act_vec();
    return {load_en, store_en, acc_we, busy, done, mask_multi, MPR_mask, mmu_d_in, acc_out};
  endfunction

  // Expected outputs k RDY-cycles after acceptance (k > n means back in IDLE).
  function automatic logic [29:0] exp_vec(int k, logic op, logic [7:0] m1, logic [7:0] din,
                                          logic we_ok, logic multi, int n,
                                          logic [7:0] acc_old, logic [7:0] acc_new);
    logic       le, se, we, bz, dn;
    logic [7:0] mk, di, ac;
    le = op && (k == 1);
    se = !op && (k == 1);
    we = !op && we_ok && (k == 3);
    bz = (k >= 1) && (k < n);
    dn = (k == n);
    mk = (k == 1) ? m1 : 8'h00;
    di = (op && (k == 1)) ? din : 8'h00;
    ac = (k >= 3) ? acc_new : acc_old;
    return {le, se, we, bz, dn, multi, mk, di, ac};
  endfunction

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (le,se,we,busy,done,multi,mask,din,acc)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one instruction (called at a negedge with the DUT idle) and check every cycle.
  // mode 0: RDY always high; 1: random RDY and stray starts; 2: 3 stalls in ISSUE, 2 in PAD.
  task automatic do_instr(input string tag, input logic op, input logic [7:0] im,
                          input logic [7:0] ac, input int mode, input logic [7:0] exp_mask,
                          input logic exp_multi, input int exp_n, input logic [7:0] exp_acc);
    int         k, t, done_at, stalls, hold;
    logic       r;
    logic [7:0] acc_old;
    acc_old = ref_acc;
    k = 0; t = 0; done_at = -1; stalls = 0; hold = 0;
    start = 1'b1; op_tam = op; imm = im; acc_in = ac; RDY = 1'b1;
    @(posedge clk);
    k = 1; t = 1;
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      check(tag, act_vec(), exp_vec(k, op, exp_mask, ac, im != 8'h00, exp_multi, exp_n,
                                    acc_old, exp_acc));
      if (done === 1'b1 && done_at < 0) done_at = t;
      if (k > exp_n) break;
      r = 1'b1;
      if (mode == 1) begin
        start  = 1'($urandom);
        op_tam = 1'($urandom);
        imm    = 8'($urandom);
        acc_in = 8'($urandom);
        r      = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        start  = (k == 2) || (k == exp_n);
        op_tam = ~op;
        imm    = ~im;
        acc_in = ~ac;
        if ((k == 1 && hold < 3) || (k == 3 && hold >= 3 && hold < 5)) begin
          r = 1'b0;
          hold++;
        end
      end else begin
        start = 1'b0;
      end
      RDY = r;
      if (!r && k < exp_n) stalls++;
      @(posedge clk);
      if (r) k++;
      t++;
    end
    start = 1'b0;
    RDY   = 1'b1;
    if (k <= exp_n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: reached step %0d required %0d", tag, k, exp_n + 1);
    end
    check_int({tag, "_done_cycle"}, done_at, exp_n + stalls);
    if (mode == 2) check_int({tag, "_stalls"}, stalls, 5);
    if (op) begin
      for (int i = 0; i < 8; i++) if (im[i]) ref_mpr[i] = ac;
    end
    ref_acc = exp_acc;
  endtask

  initial begin
    logic       op;
    logic [7:0] im, ac, lowm, emask, eacc;
    int         low, pop;

    tbl[0]  = '{1'b1, 8'h04, 8'hF8, 8'h04, 1'b0, 5, 8'h00};
    tbl[1]  = '{1'b0, 8'h04, 8'h99, 8'h04, 1'b0, 4, 8'hF8};
    tbl[2]  = '{1'b1, 8'h20, 8'h3C, 8'h20, 1'b0, 5, 8'hF8};
    tbl[3]  = '{1'b0, 8'h20, 8'h11, 8'h20, 1'b0, 4, 8'h3C};
    tbl[4]  = '{1'b1, 8'h08, 8'h5A, 8'h08, 1'b0, 5, 8'h3C};
    tbl[5]  = '{1'b0, 8'h28, 8'h00, 8'h08, 1'b1, 4, 8'h5A};
    tbl[6]  = '{1'b0, 8'h00, 8'hC3, 8'h00, 1'b0, 4, 8'h5A};
    tbl[7]  = '{1'b1, 8'h00, 8'h77, 8'h00, 1'b0, 5, 8'h5A};
    tbl[8]  = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 5, 8'h5A};
    tbl[9]  = '{1'b0, 8'h04, 8'hEE, 8'h04, 1'b0, 4, 8'h00};
    tbl[10] = '{1'b0, 8'hC0, 8'h00, 8'h40, 1'b1, 4, 8'h00};
    tbl[11] = '{1'b1, 8'h81, 8'hE7, 8'h81, 1'b0, 5, 8'h00};

    for (int i = 0; i < 8; i++) ref_mpr[i] = 8'h00;
    ref_acc = 8'h00;

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_state", act_vec(), 30'h0);
    reset   = 1'b0;
    mmu_clr = 1'b0;

    for (int i = 0; i < 12; i++)
      do_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].imm, tbl[i].acc, 0,
               tbl[i].exp_mask, tbl[i].exp_multi, tbl[i].exp_n, tbl[i].exp_acc);

    // Stalls in ISSUE and PAD with stray start pulses while busy and in DONE
    do_instr("stall_tma", 1'b0, 8'h80, 8'h00, 2, 8'h80, 1'b0, 4, 8'hE7);
    do_instr("stall_tam", 1'b1, 8'h12, 8'h6B, 2, 8'h12, 1'b0, 5, 8'hE7);

    // Reset during XFER of a TMA aborts it; next start accepted right after release
    start = 1'b1; op_tam = 1'b0; imm = 8'h02; acc_in = 8'h00; RDY = 1'b1;
    @(posedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_in_xfer", act_vec(), 30'h0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held", act_vec(), 30'h0);
    reset   = 1'b0;
    ref_acc = 8'h00;
    do_instr("after_reset", 1'b1, 8'h40, 8'hB4, 0, 8'h40, 1'b0, 5, 8'h00);
    @(negedge clk);
    check("idle_after", act_vec(), 30'h0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      op = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       im = 8'h00;
        1:       im = 8'h01 << $urandom_range(0, 7);
        default: im = 8'($urandom);
      endcase
      ac  = 8'($urandom);
      low = -1;
      pop = 0;
      for (int b = 0; b < 8; b++) begin
        if (im[b]) begin
          pop++;
          if (low < 0) low = b;
        end
      end
      lowm  = (low < 0) ? 8'h00 : (8'h01 << low);
      emask = op ? im : lowm;
      eacc  = (!op && low >= 0) ? ref_mpr[low] : ref_acc;
      do_instr($sformatf("rnd%0d", n), op, im, ac, 1, emask, !op && (pop > 1),
               op ? 5 : 4, eacc);
    end

    for (int i = 0; i < 8; i++)
      check_int($sformatf("mpr%0d", i), int'(mmu_mpr[i]), int'(ref_mpr[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
